// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider controller for the execute stage.
// Stalls the pipeline while dividing and returns {remainder, quotient}.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic                 annul,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 stall,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    neg2c = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
    abs_val = (en && v[WIDTH-1]) ? neg2c(v) : v;
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]      quo_q, quo_d;
  logic [WIDTH-1:0]      dvs_q, dvs_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic [2*WIDTH-1:0]    result_q, result_d;

  logic [WIDTH:0]        rem_sh_s;
  logic [WIDTH:0]        diff_s;
  logic                  qbit_s;
  logic [WIDTH-1:0]      step_rem_s;
  logic [WIDTH-1:0]      step_quo_s;
  logic [WIDTH-1:0]      fin_rem_s;
  logic [WIDTH-1:0]      fin_quo_s;
  logic                  accept_s;
  logic                  dbz_s;

  // One restoring step: the W+1-bit difference is negative exactly when its MSB is set,
  // because the shifted partial remainder is always below twice the divisor.
  always_comb begin
    rem_sh_s   = {rem_q, quo_q[WIDTH-1]};
    diff_s     = rem_sh_s - {1'b0, dvs_q};
    qbit_s     = ~diff_s[WIDTH];
    step_rem_s = qbit_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
    step_quo_s = {quo_q[WIDTH-2:0], qbit_s};
    fin_quo_s  = qneg_q ? neg2c(step_quo_s) : step_quo_s;
    fin_rem_s  = rneg_q ? neg2c(step_rem_s) : step_rem_s;
  end

  // Next-state, datapath load and stall decode; annul overrides everything at the end.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    stall    = 1'b0;
    accept_s = (state_q != S_BUSY) && start && !annul;
    dbz_s    = (b == {WIDTH{1'b0}});

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (dbz_s) begin
            state_d  = S_DONE;
            result_d = {a, {WIDTH{1'b1}}};
          end else begin
            state_d = S_BUSY;
            stall   = 1'b1;
            cnt_d   = {CW{1'b0}};
            rem_d   = {WIDTH{1'b0}};
            quo_d   = abs_val(a, signed_div);
            dvs_d   = abs_val(b, signed_div);
            qneg_d  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d  = signed_div & a[WIDTH-1];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          cnt_d    = {CW{1'b0}};
          result_d = {fin_rem_s, fin_quo_s};
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (annul) begin
      state_d  = S_IDLE;
      stall    = 1'b0;
      cnt_d    = {CW{1'b0}};
      result_d = result_q;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed table-driven bench for div_ctrl plus hand-written multi-cycle sequences.
module tb_div_ctrl;

  localparam int W = 32;

  logic            clk;
  logic            resetn;
  logic            start;
  logic            signed_div;
  logic            annul;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            stall;
  logic            ready;
  logic [2*W-1:0]  result;

  int total;
  int bad;

  div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .annul(annul), .a(a), .b(b), .stall(stall), .ready(ready), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic           sgn;
    logic [2*W-1:0] exp_res;
    int             exp_lat;
    int             exp_stalls;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one divide from IDLE/DONE and follow it to its ready pulse.
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic sgn, input logic [2*W-1:0] exp_res,
                        input int exp_lat, input int exp_stalls, input logic chk_pulse);
    int lat;
    int nst;
    a = va; b = vb; signed_div = sgn; start = 1'b1;
    #1;
    chk({tag, "_stall_acc"}, {63'd0, stall}, {63'd0, (exp_stalls != 0)});
    nst = stall ? 1 : 0;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (stall) nst++;
      if (ready) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stalls"}, 64'(nst), 64'(exp_stalls));
    chk({tag, "_result"}, result, exp_res);
    if (chk_pulse) begin
      @(negedge clk);
      chk({tag, "_pulse"}, {63'd0, ready}, 64'd0);
    end
  endtask

  task automatic no_ready(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (ready || stall) seen++;
    end
    chk({tag, "_quiet"}, 64'(seen), 64'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = 32'd0; b = 32'd0;
    resetn = 1'b0;

    vecs[0] = '{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 33, 33};
    vecs[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 33};
    vecs[2] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 33, 33};
    vecs[3] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 64'h80000000_00000000, 33, 33};
    vecs[4] = '{32'h00001234,   32'd0,          1'b0, 64'h00001234_FFFFFFFF, 1,  0};
    vecs[5] = '{32'hFFFFFFF9,   32'd0,          1'b1, 64'hFFFFFFF9_FFFFFFFF, 1,  0};
    vecs[6] = '{32'd7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, 33, 33};
    vecs[7] = '{32'd1000,       32'd33,         1'b0, 64'h0000000A_0000001E, 33, 33};

    repeat (2) @(negedge clk);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_result", result, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].sgn,
             vecs[i].exp_res, vecs[i].exp_lat, vecs[i].exp_stalls, 1'b1);
      @(negedge clk);
    end

    // Back-to-back: second start issued in the ready cycle of the first.
    run_op("b2b_first", 32'd15, 32'd4, 1'b0, 64'h00000003_00000003, 33, 33, 1'b0);
    run_op("b2b_second", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 33, 1'b1);

    // Annul while busy at counter 10.
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 11; k++) @(negedge clk);
    chk("annul_pre_stall", {63'd0, stall}, 64'd1);
    annul = 1'b1;
    #1;
    chk("annul_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1 annul = 1'b0;
    no_ready("annul", 40);
    chk("annul_keep", result, 64'h00000000_00000003);
    run_op("post_annul", 32'd10, 32'd3, 1'b0, 64'h00000001_00000003, 33, 33, 1'b1);

    // Annul together with start: the request is dropped.
    @(negedge clk);
    a = 32'd50; b = 32'd5; start = 1'b1; annul = 1'b1;
    #1;
    chk("annul_start_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1 start = 1'b0; annul = 1'b0;
    no_ready("annul_start", 40);
    chk("annul_start_keep", result, 64'h00000001_00000003);

    // Reset pulsed in the middle of a divide.
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_stall", {63'd0, stall}, 64'd0);
    chk("mid_rst_ready", {63'd0, ready}, 64'd0);
    chk("mid_rst_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    no_ready("mid_rst", 40);
    chk("mid_rst_result_after", result, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
